// File: rtl/sen_sched_pkg.sv
// Shared constants for the sensor command scheduler: response codes,
// command field positions and the dispatch FSM state type.
package sen_sched_pkg;

    localparam logic [7:0] RSP_OK      = 8'h00;
    localparam logic [7:0] RSP_BADID   = 8'h01;
    localparam logic [7:0] RSP_TIMEOUT = 8'h02;
    localparam logic [7:0] RSP_OVF     = 8'h03;

    localparam int SEN_ID_MSB = 39;
    localparam int SEN_ID_LSB = 32;
    localparam int SEN_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DISPATCH,
        ST_WAIT,
        ST_RESP
    } state_t;

endpackage

// File: rtl/sen_fifo.sv
// Synchronous command FIFO with occupancy count; a push while full is
// accepted only when a pop happens in the same cycle.
module sen_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/sen_sched.sv
// Sensor command scheduler: queues 40-bit commands, dispatches them one at a
// time to the addressed sensor and returns one response per command.
module sen_sched
    import sen_sched_pkg::*;
#(
    parameter int NUM_SEN = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 50000
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic [39:0]              sen_cmd,
    input  logic                     sen_cmd_flag,
    output logic [NUM_SEN-1:0]       sen_req,
    output logic [31:0]              sen_wdata,
    input  logic [NUM_SEN-1:0]       sen_done,
    input  logic [31:0]              sen_rdata,
    output logic                     rsp_flag,
    output logic [7:0]               rsp_code,
    output logic [31:0]              rsp_data,
    input  logic                     rsp_ready,
    output logic [$clog2(DEPTH):0]   q_cnt
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t                 state;
    logic [39:0]            head;
    logic [7:0]             head_id;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_pop;
    logic                   ovf_pend;
    logic                   ovf_set;
    logic                   done_hit;
    logic                   tmo_hit;
    logic [NUM_SEN-1:0]     cmd_sel;
    logic [SEN_DATA_W-1:0]  cmd_data;
    logic [CNT_W-1:0]       tmo_cnt;

    sen_fifo #(
        .WIDTH (40),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (sys_clk),
        .rst_n (sys_rst),
        .push  (sen_cmd_flag),
        .din   (sen_cmd),
        .pop   (fifo_pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (q_cnt)
    );

    assign head_id  = head[SEN_ID_MSB:SEN_ID_LSB];
    assign fifo_pop = (state == ST_IDLE) && !ovf_pend && !fifo_empty;
    assign ovf_set  = sen_cmd_flag && fifo_full && !fifo_pop;
    // sen_req is one-hot on the active sensor during WAIT, so it doubles as the done mask.
    assign done_hit = |(sen_done & sen_req);
    assign tmo_hit  = (tmo_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state     <= ST_IDLE;
            ovf_pend  <= 1'b0;
            tmo_cnt   <= '0;
            cmd_sel   <= '0;
            cmd_data  <= '0;
            sen_req   <= '0;
            sen_wdata <= '0;
            rsp_flag  <= 1'b0;
            rsp_code  <= '0;
            rsp_data  <= '0;
        end else begin
            // A new overflow in the same cycle IDLE consumes the old one stays pending.
            if (ovf_set)
                ovf_pend <= 1'b1;
            else if (state == ST_IDLE)
                ovf_pend <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (ovf_pend) begin
                        rsp_code <= RSP_OVF;
                        rsp_data <= '0;
                        state    <= ST_RESP;
                    end else if (!fifo_empty) begin
                        if (int'(head_id) < NUM_SEN) begin
                            cmd_sel  <= NUM_SEN'(1) << head_id;
                            cmd_data <= head[SEN_DATA_W-1:0];
                            state    <= ST_DISPATCH;
                        end else begin
                            rsp_code <= RSP_BADID;
                            rsp_data <= '0;
                            state    <= ST_RESP;
                        end
                    end
                end
                ST_DISPATCH: begin
                    sen_req   <= cmd_sel;
                    sen_wdata <= cmd_data;
                    tmo_cnt   <= '0;
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (done_hit) begin
                        rsp_code <= RSP_OK;
                        rsp_data <= sen_rdata;
                        sen_req  <= '0;
                        state    <= ST_RESP;
                    end else if (tmo_hit) begin
                        rsp_code <= RSP_TIMEOUT;
                        rsp_data <= '0;
                        sen_req  <= '0;
                        state    <= ST_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (!rsp_flag) begin
                        rsp_flag <= 1'b1;
                    end else if (rsp_ready) begin
                        rsp_flag <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
